iir_settle_reader: RTL and testbench



---
 rtl/iir_pkg.sv | 49 ++++
 rtl/iir_tc_lut.sv | 11 +
 rtl/iir_settle_reader.sv | 153 +++++++++++++++
 tb/tb_iir_settle_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter chain: time-constant codes, code->shift map
// and the settle-reader FSM states.
package iir_pkg;

  localparam int unsigned DATA_W  = 36;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned SHIFT_W = 5;

  localparam logic [CODE_W-1:0] TC_10US    = 4'd1;
  localparam logic [CODE_W-1:0] TC_30US    = 4'd2;
  localparam logic [CODE_W-1:0] TC_100US   = 4'd3;
  localparam logic [CODE_W-1:0] TC_300US   = 4'd4;
  localparam logic [CODE_W-1:0] TC_1MS     = 4'd5;
  localparam logic [CODE_W-1:0] TC_3MS     = 4'd6;
  localparam logic [CODE_W-1:0] TC_10MS    = 4'd7;
  localparam logic [CODE_W-1:0] TC_30MS    = 4'd8;
  localparam logic [CODE_W-1:0] TC_100MS   = 4'd9;
  localparam logic [CODE_W-1:0] TC_300MS   = 4'd10;
  localparam logic [CODE_W-1:0] TC_1S      = 4'd11;
  localparam logic [CODE_W-1:0] TC_3S      = 4'd12;
  localparam logic [CODE_W-1:0] TC_DEFAULT = TC_300MS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_HOLD
  } state_e;

  // Filter time constant is 2^shift cycles; unused codes fall back to the default shift.
  function automatic logic [SHIFT_W-1:0] tc_shift(input logic [CODE_W-1:0] code);
    case (code)
      TC_10US:  tc_shift = 5'd3;
      TC_30US:  tc_shift = 5'd5;
      TC_100US: tc_shift = 5'd7;
      TC_300US: tc_shift = 5'd8;
      TC_1MS:   tc_shift = 5'd10;
      TC_3MS:   tc_shift = 5'd12;
      TC_10MS:  tc_shift = 5'd13;
      TC_30MS:  tc_shift = 5'd15;
      TC_100MS: tc_shift = 5'd17;
      TC_300MS: tc_shift = 5'd18;
      TC_1S:    tc_shift = 5'd20;
      TC_3S:    tc_shift = 5'd22;
      default:  tc_shift = 5'd18;
    endcase
  endfunction

endpackage

// File: rtl/iir_tc_lut.sv
// Combinational time-constant code -> shift lookup, shared with the filter-side control.
module iir_tc_lut
  import iir_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [SHIFT_W-1:0] shift_c
);

  assign shift_c = tc_shift(code);

endmodule

// File: rtl/iir_settle_reader.sv
// Waits SETTLE_TC filter time constants after a request, averages 2^AVG_LOG2 samples
// and offers the result on valid/ready. Define IIR_SETTLE_READER_AUTO_EN for continuous mode.
module iir_settle_reader
  import iir_pkg::*;
#(
  parameter int unsigned SETTLE_TC = 5,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned CNT_W     = 28
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [CODE_W-1:0]        i_coefficient,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_start,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_busy,
  output logic                     o_restart
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned AC_W  = AVG_LOG2 + 1;
  localparam logic [AC_W-1:0] AC_LAST = AC_W'((1 << AVG_LOG2) - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CODE_W-1:0]         code_q, code_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [AC_W-1:0]           acc_cnt_q, acc_cnt_d;
  logic                      valid_q, valid_d;
  logic signed [DATA_W-1:0]  data_q, data_d;
  logic                      busy_q, busy_d;
  logic                      restart_q, restart_d;

  logic [SHIFT_W-1:0]        shift_in;
  logic [CNT_W-1:0]          settle_m1;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      coef_change;

  iir_tc_lut u_lut_in (.code(i_coefficient), .shift_c(shift_in));

  assign settle_m1   = (CNT_W'(SETTLE_TC) << shift_in) - CNT_W'(1);
  assign coef_change = (i_coefficient != code_q);

`ifdef IIR_SETTLE_READER_AUTO_EN
  logic [SHIFT_W-1:0] shift_q;
  logic [CNT_W-1:0]   one_tc_m1;

  iir_tc_lut u_lut_q (.code(code_q), .shift_c(shift_q));

  assign one_tc_m1 = (CNT_W'(1) << shift_q) - CNT_W'(1);
`endif

  // First sample of a window is loaded rather than added.
  always_comb begin
    acc_base = acc_q;
    if (acc_cnt_q == '0) acc_base = '0;
    acc_sum = acc_base + ACC_W'(i_data);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    restart_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          code_d  = i_coefficient;
          cnt_d   = settle_m1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE, ST_ACCUM: begin
        if (coef_change) begin
          code_d    = i_coefficient;
          cnt_d     = settle_m1;
          acc_d     = '0;
          acc_cnt_d = '0;
          restart_d = 1'b1;
          state_d   = ST_SETTLE;
        end else if (state_q == ST_SETTLE) begin
          if (cnt_q == '0) begin
            acc_cnt_d = '0;
            state_d   = ST_ACCUM;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          acc_d = acc_sum;
          if (acc_cnt_q == AC_LAST) begin
            data_d  = DATA_W'(acc_sum >>> AVG_LOG2);
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            acc_cnt_d = acc_cnt_q + AC_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
`ifdef IIR_SETTLE_READER_AUTO_EN
          cnt_d   = one_tc_m1;
          state_d = ST_SETTLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      restart_q <= restart_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_busy    = busy_q;
  assign o_restart = restart_q;

endmodule

// File: tb/tb_iir_settle_reader.sv
// Scoreboard bench for iir_settle_reader: expected results computed from the sample
// history and the settle/average rules, checked by an independent handshake monitor.
module tb_iir_settle_reader;
  import iir_pkg::*;

  localparam int STC = 5;
  localparam int D   = 4;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n = 1'b0;
  logic [3:0]               i_coefficient = 4'd1;
  logic signed [35:0]       i_data = '0;
  logic                     i_start = 1'b0;
  logic                     i_ready = 1'b0;
  logic                     o_valid;
  logic signed [35:0]       o_data;
  logic                     o_busy;
  logic                     o_restart;

  iir_settle_reader #(.SETTLE_TC(5), .AVG_LOG2(2), .CNT_W(28)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_coefficient(i_coefficient), .i_data(i_data),
    .i_start(i_start), .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data),
    .o_busy(o_busy), .o_restart(o_restart)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { longint data; int edge_n; } exp_t;

  int                 SHIFT_TAB [16] = '{18, 3, 5, 7, 8, 10, 12, 13, 15, 17, 18, 20, 22, 18, 18, 18};
  logic signed [35:0] data_mem [0:65535];
  exp_t               exp_q[$];
  int                 rst_q[$];
  int                 cyc = 0;
  int                 errors = 0;
  int                 checks = 0;
  int                 hs_count = 0;

  function automatic int settle_n(int code);
    return STC << SHIFT_TAB[code];
  endfunction

  // Expected average of the D samples ending at the edge where o_valid rises.
  function automatic void push_expect(int exp_edge);
    exp_t   e;
    longint sum = 0;
    longint q;
    for (int i = 0; i < D; i++) sum += longint'(data_mem[exp_edge - i]);
    q = sum / D;
    if ((sum % D) != 0 && sum < 0) q = q - 1;
    e.data   = q;
    e.edge_n = exp_edge;
    exp_q.push_back(e);
  endfunction

  function automatic void set_pattern(int exp_edge, int pat);
    for (int i = 0; i < D; i++) begin
      case (pat)
        1: data_mem[exp_edge - 3 + i] = 36'sd1000;
        2: data_mem[exp_edge - 3 + i] = -36'(i + 1);
        3: data_mem[exp_edge - 3 + i] = (i == 0) ? 36'sd7 : 36'sd8;
        default: ;
      endcase
    end
  endfunction

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
    end
  endfunction

  // Edge counter and sample driver: the value sampled at edge e is data_mem[e].
  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [31:0] hi;
      hi = $urandom;
      data_mem[i] = {hi[3:0], $urandom};
    end
    i_data = data_mem[1];
    forever begin
      @(posedge i_clk);
      cyc++;
      #1;
      i_data = data_mem[(cyc + 1) & 16'hFFFF];
    end
  end

  // Monitor: restart pulses, HOLD stability and handshake results.
  initial begin
    logic               prev_valid = 1'b0;
    logic               prev_hs = 1'b0;
    logic signed [35:0] prev_data = '0;
    int                 rise = 0;
    exp_t               e;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (o_restart) begin
          if (rst_q.size() == 0) check("restart_unexpected", cyc, -1);
          else check("restart_edge", cyc, rst_q.pop_front());
        end
        if (o_valid && !prev_valid) rise = cyc;
        if (prev_valid && !prev_hs) begin
          check("hold_valid", longint'(o_valid), 1);
          check("hold_data", longint'(o_data), longint'(prev_data));
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) check("result_unexpected", longint'(o_data), -1);
          else begin
            e = exp_q.pop_front();
            check("result_data", longint'(o_data), e.data);
            check("result_edge", rise, e.edge_n);
          end
          hs_count++;
        end
        prev_valid = o_valid;
        prev_hs    = o_valid && i_ready;
        prev_data  = o_data;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic begin_meas(input int code, output int k);
    i_coefficient = 4'(code);
    i_start = 1'b1;
    k = cyc + 1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_hs(input int budget);
    int c0 = hs_count;
    int n = 0;
    while (hs_count == c0 && n < budget) begin
      step();
      n++;
    end
    if (hs_count == c0) check("handshake_timeout", n, -1);
  endtask

  task automatic wait_until(input int edge_n);
    int n = 0;
    while (cyc < edge_n && n < 5000) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, longint'(o_valid), 0);
    check({tag, "_data"}, longint'(o_data), 0);
    check({tag, "_busy"}, longint'(o_busy), 0);
    check({tag, "_restart"}, longint'(o_restart), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid_low"}, longint'(o_valid), 0);
    check({tag, "_busy_low"}, longint'(o_busy), 0);
  endtask

  initial begin
    int k, r, ee, code, code2, n, hs0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    #1;
    i_rst_n = 1'b1;
    wait_until(9);

`ifdef IIR_SETTLE_READER_AUTO_EN
    i_ready = 1'b1;
    begin_meas(3, k);
    ee = k + settle_n(3) + D;
    for (int i = 0; i < 3; i++) push_expect(ee + i * ((1 << SHIFT_TAB[3]) + D + 1));
    for (int i = 0; i < 3; i++) wait_hs(settle_n(3) + 200);
`else
    // Constant input, ready held high before the result exists.
    i_ready = 1'b1;
    begin_meas(1, k);
    check("busy_in_settle", longint'(o_busy), 1);
    ee = k + settle_n(1) + D;
    set_pattern(ee, 1);
    push_expect(ee);
    wait_hs(200);
    check_idle("const");

    // Floor rounding on negative and positive averages.
    for (int pat = 2; pat <= 3; pat++) begin
      step();
      begin_meas(1, k);
      ee = k + settle_n(1) + D;
      set_pattern(ee, pat);
      push_expect(ee);
      wait_hs(200);
      check_idle("pattern");
    end

    // Coefficient change 1->2 twenty cycles into settling.
    step();
    begin_meas(1, k);
    repeat (19) step();
    i_coefficient = 4'd2;
    r = k + 20;
    rst_q.push_back(r);
    push_expect(r + settle_n(2) + D);
    wait_hs(400);
    check_idle("restart");

    // Ready withheld in HOLD; stray start and coefficient change are ignored.
    i_ready = 1'b0;
    step();
    begin_meas(2, k);
    ee = k + settle_n(2) + D;
    push_expect(ee);
    wait_until(ee);
    step();
    check("hold_valid_up", longint'(o_valid), 1);
    hs0 = hs_count;
    for (int i = 0; i < 30; i++) begin
      i_start = (i == 5);
      if (i == 8) i_coefficient = 4'd3;
      step();
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    wait_hs(10);
    repeat (5) step();
    check("single_handshake", hs_count - hs0, 1);
    check_idle("after_hold");

    // Randomised measurements with optional restarts in SETTLE or ACCUM.
    for (int t = 0; t < 6; t++) begin
      code = $urandom_range(1, 3);
      n = $urandom_range(0, 10);
      i_ready = ($urandom_range(0, 1) == 1);
      step();
      begin_meas(code, k);
      if ($urandom_range(0, 1) == 1) begin
        r = k + $urandom_range(1, settle_n(code) + D);
        code2 = (code % 3) + 1;
        wait_until(r - 1);
        i_coefficient = 4'(code2);
        rst_q.push_back(r);
        ee = r + settle_n(code2) + D;
      end else begin
        ee = k + settle_n(code) + D;
      end
      push_expect(ee);
      if (!i_ready) begin
        wait_until(ee + n);
        i_ready = 1'b1;
      end
      wait_hs(settle_n(3) + 100);
      check_idle("random");
    end

    // Asynchronous reset in the middle of averaging drops the pending result.
    step();
    begin_meas(1, k);
    wait_until(k + settle_n(1) + 2);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    step();
    step();
    i_rst_n = 1'b1;
    step();
    begin_meas(1, k);
    ee = k + settle_n(1) + D;
    push_expect(ee);
    wait_hs(200);
    check_idle("post_reset");
`endif

    repeat (10) step();
    check("exp_queue_empty", exp_q.size(), 0);
    check("restart_queue_empty", rst_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1);
  end

endmodule
